// File: rtl/systolic_array_nxn.sv
// rtl/systolic_array_nxn.sv - output-stationary NxN systolic matrix multiplier with input skew and start/done job control.
// Optional macro SYSTOLIC_SAT_EN: saturating accumulation (default: wrap modulo 2^ACC_W).
module systolic_array_nxn #(
  parameter int N     = 4,
  parameter int DW    = 4,
  parameter int ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [N*DW-1:0]      a_col,
  input  logic [N*DW-1:0]      b_row,
  output logic                 busy,
  output logic                 done,
  output logic                 c_valid,
  output logic [N*N*ACC_W-1:0] c_out
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          clr;

  assign accept = in_valid & in_ready;
  assign clr    = (state == IDLE) & start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      c_valid  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= STREAM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            c_valid  <= 1'b0;
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
            cnt      <= '0;
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            c_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DW-1:0] a_edge   [N];
  logic          a_edge_v [N];
  logic [DW-1:0] b_edge   [N];
  logic          b_edge_v [N];

  // Lane i passes through i+1 registers so PE(i,j) sees beat k at edge E+1+i+j.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_q  [i+1];
    logic          av_q [i+1];
    logic [DW-1:0] b_q  [i+1];
    logic          bv_q [i+1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int d = 0; d <= i; d++) begin
          a_q[d] <= '0; av_q[d] <= 1'b0; b_q[d] <= '0; bv_q[d] <= 1'b0;
        end
      end else if (clr) begin
        for (int d = 0; d <= i; d++) begin
          a_q[d] <= '0; av_q[d] <= 1'b0; b_q[d] <= '0; bv_q[d] <= 1'b0;
        end
      end else begin
        a_q[0]  <= a_col[i*DW +: DW];
        av_q[0] <= accept;
        b_q[0]  <= b_row[i*DW +: DW];
        bv_q[0] <= accept;
        for (int d = 1; d <= i; d++) begin
          a_q[d] <= a_q[d-1]; av_q[d] <= av_q[d-1];
          b_q[d] <= b_q[d-1]; bv_q[d] <= bv_q[d-1];
        end
      end
    end

    assign a_edge[i]   = a_q[i];
    assign a_edge_v[i] = av_q[i];
    assign b_edge[i]   = b_q[i];
    assign b_edge_v[i] = bv_q[i];
  end

  logic [DW-1:0] a_h  [N][N-1];
  logic          av_h [N][N-1];
  logic [DW-1:0] b_v  [N-1][N];
  logic          bv_v [N-1][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0]            a_in, b_in;
      logic                     av_in, bv_in;
      logic [DW-1:0]            a_r, b_r;
      logic                     av_r, bv_r;
      logic signed [2*DW-1:0]   prod;
      logic signed [ACC_W-1:0]  prod_x;
      logic signed [ACC_W-1:0]  acc_r;
      logic signed [ACC_W-1:0]  acc_nxt;

      if (j == 0) begin : g_a_edge
        assign a_in  = a_edge[i];
        assign av_in = a_edge_v[i];
      end else begin : g_a_left
        assign a_in  = a_h[i][j-1];
        assign av_in = av_h[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in  = b_edge[j];
        assign bv_in = b_edge_v[j];
      end else begin : g_b_up
        assign b_in  = b_v[i-1][j];
        assign bv_in = bv_v[i-1][j];
      end

      assign prod   = $signed(a_in) * $signed(b_in);
      assign prod_x = ACC_W'(prod);

`ifdef SYSTOLIC_SAT_EN
      logic signed [ACC_W:0] wide;
      assign wide = (ACC_W+1)'(acc_r) + (ACC_W+1)'(prod_x);
      always_comb begin
        acc_nxt = wide[ACC_W-1:0];
        if (wide[ACC_W] != wide[ACC_W-1])
          acc_nxt = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      assign acc_nxt = acc_r + prod_x;
`endif

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_r <= '0; av_r <= 1'b0; b_r <= '0; bv_r <= 1'b0; acc_r <= '0;
        end else if (clr) begin
          a_r <= '0; av_r <= 1'b0; b_r <= '0; bv_r <= 1'b0; acc_r <= '0;
        end else begin
          a_r  <= a_in;
          av_r <= av_in;
          b_r  <= b_in;
          bv_r <= bv_in;
          if (av_in && bv_in) acc_r <= acc_nxt;
        end
      end

      if (j < N - 1) begin : g_a_out
        assign a_h[i][j]  = a_r;
        assign av_h[i][j] = av_r;
      end
      if (i < N - 1) begin : g_b_out
        assign b_v[i][j]  = b_r;
        assign bv_v[i][j] = bv_r;
      end

      assign c_out[(i*N+j)*ACC_W +: ACC_W] = acc_r;
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb/tb_systolic_array_nxn.sv - directed self-checking bench for systolic_array_nxn (N=4, DW=4, ACC_W=16).
module tb_systolic_array_nxn;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [N*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic            busy;
  logic            done;
  logic            c_valid;
  logic [N*N*AW-1:0] c_out;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] am [N][N];
  logic signed [DW-1:0] bm [N][N];

  always #5 clk = ~clk;

  systolic_array_nxn #(.N(N), .DW(DW), .ACC_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a_col(a_col), .b_row(b_row), .busy(busy), .done(done),
    .c_valid(c_valid), .c_out(c_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = DW'(av);
        bm[i][j] = DW'(bv);
      end
  endtask

  function automatic logic [15:0] expc(input int i, input int j, input int k);
    int acc;
`ifndef SYSTOLIC_SAT_EN
    logic [15:0] t;
`endif
    acc = 0;
    for (int kk = 0; kk < k; kk++) begin
      acc += int'(am[i][kk % N]) * int'(bm[kk % N][j]);
`ifdef SYSTOLIC_SAT_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`else
      t = acc[15:0];
      acc = int'($signed(t));
`endif
    end
    return acc[15:0];
  endfunction

  task automatic run_job(input int k, input bit bubbles, input bit poke, input string tag);
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_start_flags"}, 32'({busy, in_ready, c_valid}), 32'(3'b110));
    for (int b = 0; b < k; b++) begin
      in_valid = 1'b1;
      in_last  = (b == k - 1);
      for (int x = 0; x < N; x++) begin
        a_col[x*DW +: DW] = am[x][b % N];
        b_row[x*DW +: DW] = bm[b % N][x];
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (bubbles && b != k - 1) begin
        a_col   = '1;
        b_row   = '1;
        in_last = 1'b1;
        step();
        in_last = 1'b0;
      end
    end
    n = 0;
    if (poke) start = 1'b1;
    while (!done && n < 40) begin
      step();
      start = 1'b0;
      n++;
    end
    chk({tag, "_done_latency"}, 32'(n), 32'(2 * N));
    chk({tag, "_done_flags"}, 32'({busy, c_valid, in_ready}), 32'(3'b010));
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), 32'(c_out[(i*N+j)*AW +: AW]), 32'(expc(i, j, k)));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; a_col = '0; b_row = '0;
    #1 reset = 1'b0;
    #11;
    chk("rst_flags", 32'({in_ready, busy, done, c_valid}), 32'(0));
    chk("rst_cout_zero", 32'(c_out == '0), 32'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    fill(1, 1);
    run_job(4, 1'b0, 1'b0, "ones");

    fill(-8, -8);
    run_job(1, 1'b0, 1'b0, "negneg");
    step();
    chk("cvalid_held", 32'(c_valid), 32'(1));
    fill(-8, 7);
    run_job(1, 1'b0, 1'b0, "negpos");

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = (i == j) ? DW'(1) : DW'(0);
        bm[i][j] = DW'(i * N + j - 8);
      end
    run_job(4, 1'b1, 1'b1, "bubble");
    step();
    step();
    chk("drain_start_ignored", 32'({in_ready, busy}), 32'(0));

    fill(3, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int x = 0; x < N; x++) begin
      a_col[x*DW +: DW] = 4'd3;
      b_row[x*DW +: DW] = 4'd3;
    end
    step();
    step();
    step();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_flags", 32'({in_ready, busy, done, c_valid}), 32'(0));
    chk("midrst_cout_zero", 32'(c_out == '0), 32'(1));
    step();
    reset = 1'b1;
    step();
    fill(2, -3);
    run_job(4, 1'b0, 1'b0, "post_rst");

    fill(-8, -8);
    run_job(520, 1'b0, 1'b0, "overflow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
